// File: rtl/chip8_fb_scanout_if.sv
// Pixel stream bundle between the framebuffer scanout and the video path.
// Carries one pixel per valid/ready transfer plus start-of-frame and end-of-line marks.
// master drives valid/data/flags; slave drives ready.
interface chip8_fb_scanout_if;
   logic pix_valid;
   logic pix_ready;
   logic pix_data;
   logic pix_sof;
   logic pix_eol;

   modport master (output pix_valid, output pix_data, output pix_sof, output pix_eol,
                   input  pix_ready);
   modport slave  (input  pix_valid, input  pix_data, input  pix_sof, input  pix_eol,
                   output pix_ready);
endinterface

// File: rtl/chip8_fb_scanout.sv
// CHIP-8 64x32 framebuffer scanout: walks the 256-byte RAM and streams pixels, SCALE x SCALE replicated.
// Latency: frame_start in cycle 0 -> read in cycle 1 -> first pixel (pix_sof) in cycle 3; then 1 pixel/cycle.
// Backpressure: pix_ready low freezes data/flags and all counters; optional overrun logging via CHIP8_SCANOUT_OVERRUN_EN.
module chip8_fb_scanout #(
   parameter int SCALE = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       frame_start,
   output logic       fb_rd_en,
   output logic [7:0] fb_rd_addr,
   input  logic [7:0] fb_rd_data,
   chip8_fb_scanout_if.master pix,
   output logic       busy,
   output logic       frame_done
`ifdef CHIP8_SCANOUT_OVERRUN_EN
   ,
   output logic       overrun,
   output logic [7:0] overrun_count
`endif
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_SHIFT = 2'd3;
   localparam logic [2:0] SUB_MAX = 3'(SCALE - 1);

   logic [1:0] state;
   logic [2:0] sub_x;
   logic [2:0] bit_cnt;     // 0 selects bit 7 (leftmost), 7 selects bit 0
   logic [2:0] byte_col;
   logic [2:0] sub_y;
   logic [4:0] row;
   logic [7:0] shreg;
   logic [7:0] nbuf;
   logic       nbuf_vld;
   logic       cap_pend;    // a prefetch read returns data this cycle
   logic       pix_valid_q;

   logic       sx_last, bit_last, bc_last, sy_last, last_byte;
   logic       xfer, nxt_avail, pf_go;
   logic [7:0] nxt_byte;
   logic [2:0] nxt_col;
   logic [4:0] nxt_row;

   assign sx_last   = (sub_x == SUB_MAX);
   assign bit_last  = (bit_cnt == 3'd7);
   assign bc_last   = (byte_col == 3'd7);
   assign sy_last   = (sub_y == SUB_MAX);
   assign last_byte = bc_last && sy_last && (row == 5'd31);
   assign xfer      = pix_valid_q && pix.pix_ready;

   // The next byte may still be arriving from RAM; take it straight off the read port then.
   assign nxt_avail = nbuf_vld || cap_pend;
   assign nxt_byte  = nbuf_vld ? nbuf : fb_rd_data;

   // Address of the byte following the one being shown; rows repeat SCALE times.
   assign nxt_col   = byte_col + 3'd1;
   assign nxt_row   = (bc_last && sy_last) ? row + 5'd1 : row;

   // Single outstanding prefetch, only when the buffer is empty and more bytes remain.
   assign pf_go     = (state == S_SHIFT) && !nbuf_vld && !cap_pend && !fb_rd_en && !last_byte;

   assign busy          = (state != S_IDLE);
   assign pix.pix_valid = pix_valid_q;
   assign pix.pix_data  = pix_valid_q && shreg[7];
   assign pix.pix_sof   = pix_valid_q && (row == 5'd0) && (sub_y == 3'd0) && (byte_col == 3'd0)
                          && (bit_cnt == 3'd0) && (sub_x == 3'd0);
   assign pix.pix_eol   = pix_valid_q && bc_last && bit_last && sx_last;

   // Scan sequencer: fetch/load the first byte, then shift pixels out while prefetching the next byte.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         sub_x       <= 3'd0;
         bit_cnt     <= 3'd0;
         byte_col    <= 3'd0;
         sub_y       <= 3'd0;
         row         <= 5'd0;
         shreg       <= 8'd0;
         nbuf        <= 8'd0;
         nbuf_vld    <= 1'b0;
         cap_pend    <= 1'b0;
         pix_valid_q <= 1'b0;
         fb_rd_en    <= 1'b0;
         fb_rd_addr  <= 8'd0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         fb_rd_en   <= 1'b0;
         cap_pend   <= fb_rd_en && (state == S_SHIFT);
         if (cap_pend) begin
            nbuf     <= fb_rd_data;
            nbuf_vld <= 1'b1;
         end
         case (state)
            S_IDLE: begin
               if (frame_start) begin
                  state      <= S_FETCH;
                  fb_rd_en   <= 1'b1;
                  fb_rd_addr <= 8'd0;
                  sub_x      <= 3'd0;
                  bit_cnt    <= 3'd0;
                  byte_col   <= 3'd0;
                  sub_y      <= 3'd0;
                  row        <= 5'd0;
               end
            end
            S_FETCH: state <= S_LOAD;
            S_LOAD: begin
               shreg       <= fb_rd_data;
               pix_valid_q <= 1'b1;
               state       <= S_SHIFT;
            end
            default: begin
               if (pf_go) begin
                  fb_rd_en   <= 1'b1;
                  fb_rd_addr <= {nxt_row, nxt_col};
               end
               if (!pix_valid_q) begin
                  // Starved at a byte boundary: resume as soon as the byte lands.
                  if (nxt_avail) begin
                     shreg       <= nxt_byte;
                     nbuf_vld    <= 1'b0;
                     pix_valid_q <= 1'b1;
                  end
               end else if (xfer) begin
                  if (!sx_last) begin
                     sub_x <= sub_x + 3'd1;
                  end else begin
                     sub_x <= 3'd0;
                     shreg <= {shreg[6:0], 1'b0};
                     if (!bit_last) begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end else begin
                        bit_cnt  <= 3'd0;
                        byte_col <= nxt_col;
                        if (bc_last) begin
                           if (!sy_last) begin
                              sub_y <= sub_y + 3'd1;
                           end else begin
                              sub_y <= 3'd0;
                              row   <= row + 5'd1;
                           end
                        end
                        if (last_byte) begin
                           state       <= S_IDLE;
                           pix_valid_q <= 1'b0;
                           frame_done  <= 1'b1;
                        end else if (nxt_avail) begin
                           shreg    <= nxt_byte;
                           nbuf_vld <= 1'b0;
                        end else begin
                           pix_valid_q <= 1'b0;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end

`ifdef CHIP8_SCANOUT_OVERRUN_EN
   // Log frame requests dropped because a scan is still running (frame_done cycle is already idle).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         overrun       <= 1'b0;
         overrun_count <= 8'd0;
      end else if (frame_start && busy) begin
         overrun <= 1'b1;
         if (overrun_count != 8'hFF) overrun_count <= overrun_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_chip8_fb_scanout.sv
// Directed bench for chip8_fb_scanout: SCALE=1 and SCALE=2 instances with behavioural RAMs.
// Pixel streams are compared against an image model computed from the RAM contents.
// Covers first-pixel timing, scaling, random backpressure, ignored/back-to-back requests and mid-frame reset.
module tb_chip8_fb_scanout;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // SCALE=1 instance
   logic       fs1, rd_en1, busy1, done1, ready1, rnd;
   logic [7:0] addr1, rd_data1;
   logic [7:0] ram1 [256];
   chip8_fb_scanout_if p1();
   assign p1.pix_ready = ready1;

   // SCALE=2 instance
   logic       fs2, rd_en2, busy2, done2;
   logic [7:0] addr2, rd_data2;
   logic [7:0] ram2 [256];
   chip8_fb_scanout_if p2();
   assign p2.pix_ready = 1'b1;

`ifdef CHIP8_SCANOUT_OVERRUN_EN
   logic       ov1, ov2;
   logic [7:0] oc1, oc2;
`endif

   chip8_fb_scanout #(.SCALE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .frame_start(fs1),
      .fb_rd_en(rd_en1), .fb_rd_addr(addr1), .fb_rd_data(rd_data1),
      .pix(p1), .busy(busy1), .frame_done(done1)
`ifdef CHIP8_SCANOUT_OVERRUN_EN
      , .overrun(ov1), .overrun_count(oc1)
`endif
   );

   chip8_fb_scanout #(.SCALE(2)) u2 (
      .clk(clk), .rst_n(rst_n), .frame_start(fs2),
      .fb_rd_en(rd_en2), .fb_rd_addr(addr2), .fb_rd_data(rd_data2),
      .pix(p2), .busy(busy2), .frame_done(done2)
`ifdef CHIP8_SCANOUT_OVERRUN_EN
      , .overrun(ov2), .overrun_count(oc2)
`endif
   );

   // Synchronous-read RAMs: data valid the cycle after the strobe.
   always @(posedge clk) if (rd_en1) rd_data1 <= ram1[addr1];
   always @(posedge clk) if (rd_en2) rd_data2 <= ram2[addr2];

   // Backpressure source for the SCALE=1 instance.
   initial begin
      ready1 = 1'b1;
      forever begin
         @(posedge clk); #1;
         ready1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   // Monitor for the SCALE=1 stream: image model, flag positions, stall stability.
   int x1 = 0, y1 = 0, xfers1 = 0, perr1 = 0, ferr1 = 0, serr1 = 0, eols1 = 0, dones1 = 0, stalls1 = 0;
   logic       stall1 = 1'b0, hd1, hs1, he1, me1;
   logic [7:0] mb1;
   always @(negedge clk) begin
      if (!rst_n) begin
         x1 = 0; y1 = 0; stall1 = 1'b0;
      end else begin
         if (stall1 && (!p1.pix_valid || p1.pix_data !== hd1 || p1.pix_sof !== hs1 || p1.pix_eol !== he1))
            serr1++;
         if (p1.pix_valid && !ready1) begin
            stall1 = 1'b1; stalls1++;
            hd1 = p1.pix_data; hs1 = p1.pix_sof; he1 = p1.pix_eol;
         end else begin
            stall1 = 1'b0;
         end
         if (p1.pix_valid && ready1) begin
            mb1 = ram1[8'(y1 * 8 + x1 / 8)];
            me1 = mb1[3'(7 - x1 % 8)];
            if (p1.pix_data !== me1) perr1++;
            if (p1.pix_sof !== (x1 == 0 && y1 == 0)) ferr1++;
            if (p1.pix_eol !== (x1 == 63)) ferr1++;
            if (p1.pix_eol) eols1++;
            xfers1++;
            x1++;
            if (x1 == 64) begin x1 = 0; y1 = (y1 == 31) ? 0 : y1 + 1; end
         end
         if (done1) begin
            dones1++;
            if (x1 != 0 || y1 != 0) ferr1++;
         end
      end
   end

   // Monitor for the SCALE=2 stream plus its RAM address pattern.
   int x2 = 0, y2 = 0, xfers2 = 0, perr2 = 0, ferr2 = 0, eols2 = 0, dones2 = 0;
   int lit2 = 0, litbad2 = 0, rds2 = 0, rds2_row1 = 0;
   logic       me2;
   logic [7:0] mb2;
   always @(negedge clk) begin
      if (!rst_n) begin
         x2 = 0; y2 = 0;
      end else begin
         if (rd_en2) begin
            rds2++;
            if (addr2 >= 8'd8 && addr2 < 8'd16) rds2_row1++;
         end
         if (p2.pix_valid) begin
            mb2 = ram2[8'((y2 / 2) * 8 + (x2 / 2) / 8)];
            me2 = mb2[3'(7 - (x2 / 2) % 8)];
            if (p2.pix_data !== me2) perr2++;
            if (p2.pix_sof !== (x2 == 0 && y2 == 0)) ferr2++;
            if (p2.pix_eol !== (x2 == 127)) ferr2++;
            if (p2.pix_eol) eols2++;
            // Source pixels 8,9 of row 1 land on output x 16..19 of lines 2 and 3.
            if (p2.pix_data) begin
               lit2++;
               if (y2 < 2 || y2 > 3 || x2 < 16 || x2 > 19) litbad2++;
            end
            xfers2++;
            x2++;
            if (x2 == 128) begin x2 = 0; y2 = (y2 == 63) ? 0 : y2 + 1; end
         end
         if (done2) dones2++;
      end
   end

   task automatic wait_done1(input int start, input int limit, output int n);
      n = start;
      while (!done1 && n < limit) begin tick(); n++; end
   endtask

   int n, bx, bp, bf, bd;

   initial begin
      rst_n = 1'b0; fs1 = 1'b0; fs2 = 1'b0; rnd = 1'b0;
      for (int i = 0; i < 256; i++) begin ram1[i] = 8'h00; ram2[i] = 8'h00; end
      ram1[0] = 8'h80;
      ram2[9] = 8'hC0;
      tick(); tick();

      // Reset values
      check("rst_rd_en", 32'(rd_en1), 0);
      check("rst_rd_addr", 32'(addr1), 0);
      check("rst_valid", 32'(p1.pix_valid), 0);
      check("rst_data", 32'(p1.pix_data), 0);
      check("rst_sof", 32'(p1.pix_sof), 0);
      check("rst_eol", 32'(p1.pix_eol), 0);
      check("rst_busy", 32'(busy1), 0);
      check("rst_done", 32'(done1), 0);
`ifdef CHIP8_SCANOUT_OVERRUN_EN
      check("rst_overrun", 32'(ov1), 0);
      check("rst_overrun_count", 32'(oc1), 0);
`endif
      rst_n = 1'b1;
      tick();

      // Single lit pixel at (0,0), SCALE=1
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      check("t1_c1_rd_en", 32'(rd_en1), 1);
      check("t1_c1_rd_addr", 32'(addr1), 0);
      check("t1_c1_busy", 32'(busy1), 1);
      check("t1_c1_valid", 32'(p1.pix_valid), 0);
      tick();
      check("t1_c2_valid", 32'(p1.pix_valid), 0);
      tick();
      check("t1_c3_valid", 32'(p1.pix_valid), 1);
      check("t1_c3_sof", 32'(p1.pix_sof), 1);
      check("t1_c3_data", 32'(p1.pix_data), 1);
      wait_done1(3, 3000, n);
      check("t1_done_seen", 32'(done1), 1);
      check("t1_done_cycle", n, 2051);
      check("t1_busy_at_done", 32'(busy1), 0);
      check("t1_xfers", xfers1, 2048);
      check("t1_pix_errs", perr1, 0);
      check("t1_flag_errs", ferr1, 0);
      check("t1_eols", eols1, 32);
      tick();
      check("t1_done_pulse_len", 32'(done1), 0);
      check("t1_dones", dones1, 1);

      // SCALE=2, byte 9 = 0xC0
      fs2 = 1'b1;
      tick(); fs2 = 1'b0;
      n = 1;
      while (!done2 && n < 20000) begin tick(); n++; end
      check("t2_done_seen", 32'(done2), 1);
      check("t2_done_cycle", n, 8195);
      check("t2_xfers", xfers2, 8192);
      check("t2_eols", eols2, 64);
      check("t2_lit", lit2, 8);
      check("t2_lit_misplaced", litbad2, 0);
      check("t2_pix_errs", perr2, 0);
      check("t2_flag_errs", ferr2, 0);
      check("t2_reads", rds2, 512);
      check("t2_row1_reads", rds2_row1, 16);
      tick();
      check("t2_dones", dones2, 1);

      // Checkerboard with random backpressure
      for (int i = 0; i < 256; i++) ram1[i] = ((i / 8) % 2 == 0) ? 8'hAA : 8'h55;
      bx = xfers1; bp = perr1; bf = ferr1; bd = dones1;
      rnd = 1'b1;
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      wait_done1(1, 20000, n);
      check("t3_done_seen", 32'(done1), 1);
      rnd = 1'b0;
      tick(); tick();
      check("t3_xfers", xfers1 - bx, 2048);
      check("t3_pix_errs", perr1 - bp, 0);
      check("t3_flag_errs", ferr1 - bf, 0);
      check("t3_stall_errs", serr1, 0);
      check("t3_stalls_seen", 32'(stalls1 > 0), 1);
      check("t3_dones", dones1 - bd, 1);

      // Request during a frame is dropped; request in the frame_done cycle restarts
      bx = xfers1; bp = perr1; bf = ferr1; bd = dones1;
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      for (int i = 0; i < 1000; i++) tick();
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      check("t4_busy_after_ignored", 32'(busy1), 1);
      wait_done1(0, 3000, n);
      check("t4_first_done_seen", 32'(done1), 1);
      check("t4_first_xfers", xfers1 - bx, 2048);
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      check("t4_restart_rd_en", 32'(rd_en1), 1);
      check("t4_restart_rd_addr", 32'(addr1), 0);
      check("t4_restart_busy", 32'(busy1), 1);
      wait_done1(1, 3000, n);
      check("t4_second_done_cycle", n, 2051);
      check("t4_total_xfers", xfers1 - bx, 4096);
      check("t4_pix_errs", perr1 - bp, 0);
      check("t4_flag_errs", ferr1 - bf, 0);
      tick();
      check("t4_dones", dones1 - bd, 2);
`ifdef CHIP8_SCANOUT_OVERRUN_EN
      check("t4_overrun", 32'(ov1), 1);
      check("t4_overrun_count", 32'(oc1), 1);
`endif

      // Reset at transfer 500, then a clean frame
      bx = xfers1;
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      n = 0;
      while (xfers1 - bx < 500 && n < 2000) begin tick(); n++; end
      check("t5_reached_500", xfers1 - bx, 500);
      bd = dones1;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("t5_rd_en", 32'(rd_en1), 0);
      check("t5_rd_addr", 32'(addr1), 0);
      check("t5_valid", 32'(p1.pix_valid), 0);
      check("t5_data", 32'(p1.pix_data), 0);
      check("t5_sof", 32'(p1.pix_sof), 0);
      check("t5_eol", 32'(p1.pix_eol), 0);
      check("t5_busy", 32'(busy1), 0);
      check("t5_done", 32'(done1), 0);
`ifdef CHIP8_SCANOUT_OVERRUN_EN
      check("t5_overrun", 32'(ov1), 0);
      check("t5_overrun_count", 32'(oc1), 0);
`endif
      for (int i = 0; i < 20; i++) tick();
      check("t5_no_done_after_abort", dones1 - bd, 0);
      bx = xfers1; bp = perr1; bf = ferr1;
      fs1 = 1'b1;
      tick(); fs1 = 1'b0;
      wait_done1(1, 3000, n);
      check("t5_done_cycle", n, 2051);
      check("t5_xfers", xfers1 - bx, 2048);
      check("t5_pix_errs", perr1 - bp, 0);
      check("t5_flag_errs", ferr1 - bf, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
